// File: rtl/dco_meter_pkg.sv
// Shared types and constants for the DCO frequency meter:
// FSM state encoding and the gate-window length lookup.
package dco_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_MEASURE,
    ST_HOLD
  } state_t;

  localparam int GATE_BASE_LOG2 = 6;
  localparam int GATE_CNT_W     = 10;

  // Window length in clk cycles: 64, 128, 256 or 512.
  function automatic logic [GATE_CNT_W-1:0] gate_len(input logic [1:0] sel);
    logic [GATE_CNT_W-1:0] one;
    one = GATE_CNT_W'(1);
    return one << (GATE_BASE_LOG2 + int'(sel));
  endfunction

endpackage

// File: rtl/dco_edge_sync.sv
// Brings the asynchronous DCO input into the clk domain and flags each
// rising edge with a single-cycle rise pulse.
module dco_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], d};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  // Driven only from flops, so the pulse is glitch-free.
  assign rise = sync_reg[SYNC_STAGES-1] & ~prev_reg;

endmodule

// File: rtl/dco_freq_meter.sv
// Gated DCO frequency meter: counts rising edges in a window that opens on
// the first edge seen, and reports the last edge-to-edge period.
module dco_freq_meter
  import dco_meter_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             dco_in,
  input  logic [1:0]       gate_sel,
  input  logic             start,
  input  logic             meas_ack,
  output logic             busy,
  output logic             meas_valid,
  output logic [CNT_W-1:0] edge_count,
  output logic [CNT_W-1:0] period_out,
  output logic             no_signal
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic rise;

  dco_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (dco_in),
    .rise (rise)
  );

  state_t                 state_reg, state_next;
  logic [1:0]             gsel_reg, gsel_next;
  logic [GATE_CNT_W-1:0]  gate_cnt_reg, gate_cnt_next;
  logic [CNT_W-1:0]       edge_cnt_reg, edge_cnt_next;
  logic [CNT_W-1:0]       period_cnt_reg, period_cnt_next;
  logic [CNT_W-1:0]       period_last_reg, period_last_next;
  logic [CNT_W-1:0]       edge_count_reg, edge_count_next;
  logic [CNT_W-1:0]       period_out_reg, period_out_next;
  logic                   no_signal_reg, no_signal_next;
  logic                   busy_reg, meas_valid_reg;
  logic [CNT_W-1:0]       edge_tmp, period_tmp;
  logic                   last_cycle, arm_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next       = state_reg;
    gsel_next        = gsel_reg;
    gate_cnt_next    = gate_cnt_reg;
    edge_cnt_next    = edge_cnt_reg;
    period_cnt_next  = period_cnt_reg;
    period_last_next = period_last_reg;
    edge_count_next  = edge_count_reg;
    period_out_next  = period_out_reg;
    no_signal_next   = no_signal_reg;
    arm_now          = 1'b0;
    edge_tmp         = rise ? sat_inc(edge_cnt_reg) : edge_cnt_reg;
    period_tmp       = rise ? sat_inc(period_cnt_reg) : period_last_reg;
    last_cycle       = (gate_cnt_reg == gate_len(gsel_reg) - GATE_CNT_W'(1));

    if (!ena) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) arm_now = 1'b1;
        end
        ST_ARM: begin
          if (rise) begin
            // This cycle is window cycle 0; MEASURE starts at cycle 1.
            state_next      = ST_MEASURE;
            gate_cnt_next   = GATE_CNT_W'(1);
            edge_cnt_next   = CNT_W'(1);
            period_cnt_next = '0;
          end else if (last_cycle) begin
            state_next      = ST_HOLD;
            edge_count_next = '0;
            period_out_next = '0;
            no_signal_next  = 1'b1;
          end else begin
            gate_cnt_next = gate_cnt_reg + 1'b1;
          end
        end
        ST_MEASURE: begin
          edge_cnt_next    = edge_tmp;
          period_last_next = period_tmp;
          if (rise) period_cnt_next = '0;
          else      period_cnt_next = sat_inc(period_cnt_reg);
          if (last_cycle) begin
            state_next      = ST_HOLD;
            edge_count_next = edge_tmp;
            period_out_next = period_tmp;
            no_signal_next  = 1'b0;
          end else begin
            gate_cnt_next = gate_cnt_reg + 1'b1;
          end
        end
        ST_HOLD: begin
          if (meas_ack) begin
            if (start) arm_now = 1'b1;
            else       state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end

    if (arm_now) begin
      state_next       = ST_ARM;
      gsel_next        = gate_sel;
      gate_cnt_next    = '0;
      edge_cnt_next    = '0;
      period_cnt_next  = '0;
      period_last_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gsel_reg        <= 2'd0;
      gate_cnt_reg    <= '0;
      edge_cnt_reg    <= '0;
      period_cnt_reg  <= '0;
      period_last_reg <= '0;
      edge_count_reg  <= '0;
      period_out_reg  <= '0;
      no_signal_reg   <= 1'b0;
      busy_reg        <= 1'b0;
      meas_valid_reg  <= 1'b0;
    end else begin
      gsel_reg        <= gsel_next;
      gate_cnt_reg    <= gate_cnt_next;
      edge_cnt_reg    <= edge_cnt_next;
      period_cnt_reg  <= period_cnt_next;
      period_last_reg <= period_last_next;
      edge_count_reg  <= edge_count_next;
      period_out_reg  <= period_out_next;
      no_signal_reg   <= no_signal_next;
      busy_reg        <= (state_next == ST_ARM) || (state_next == ST_MEASURE);
      meas_valid_reg  <= (state_next == ST_HOLD);
    end
  end

  assign busy       = busy_reg;
  assign meas_valid = meas_valid_reg;
  assign edge_count = edge_count_reg;
  assign period_out = period_out_reg;
  assign no_signal  = no_signal_reg;

endmodule

// File: tb/tb_dco_freq_meter.sv
// Self-checking bench for dco_freq_meter: table of measurement vectors plus
// hand-written reset, back-to-back and enable sequences, scored via a queue.
module tb_dco_freq_meter;

  localparam int CNT_W = 8;

  typedef struct {
    logic [1:0] gsel;
    int         half;
    int         edges;
    int         period;
    bit         nosig;
  } vec_t;

  typedef struct {
    int edges;
    int period;
    bit nosig;
    int lat;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             ena = 1'b0;
  logic             dco_in = 1'b0;
  logic [1:0]       gate_sel = 2'd0;
  logic             start = 1'b0;
  logic             meas_ack = 1'b0;
  logic             busy, meas_valid, no_signal;
  logic [CNT_W-1:0] edge_count, period_out;

  int   half_period = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vecs[8];

  dco_freq_meter #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .dco_in    (dco_in),
    .gate_sel  (gate_sel),
    .start     (start),
    .meas_ack  (meas_ack),
    .busy      (busy),
    .meas_valid(meas_valid),
    .edge_count(edge_count),
    .period_out(period_out),
    .no_signal (no_signal)
  );

  always #5 clk = ~clk;

  // DCO model: square wave with half_period clk cycles per level; 0 holds it low.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (half_period == 0) begin
        dco_in = 1'b0;
        cnt    = 0;
      end else begin
        cnt++;
        if (cnt >= half_period) begin
          dco_in = ~dco_in;
          cnt    = 0;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Called on the negedge where start is driven; returns once meas_valid is seen.
  task automatic wait_valid(input bit inject, output int lat, output bit ok);
    ok  = 1'b0;
    lat = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (i == 0) begin
        start    = 1'b0;
        meas_ack = 1'b0;
        check("busy_after_start", int'(busy), 1);
        check("valid_after_start", int'(meas_valid), 0);
      end
      if (inject && i == 20) begin
        start    = 1'b1;
        meas_ack = 1'b1;
      end
      if (inject && i == 21) begin
        start    = 1'b0;
        meas_ack = 1'b0;
      end
      if (meas_valid) begin
        ok  = 1'b1;
        lat = i;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL timeout waiting for meas_valid actual=0 required=1");
      if (sb.size() > 0) void'(sb.pop_front());
    end
  endtask

  task automatic check_result(input int lat);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty actual=0 required=1");
      return;
    end
    e = sb.pop_front();
    $display("txn gate_sel=%0d edge_count=%0d period_out=%0d no_signal=%0d lat=%0d",
             gate_sel, edge_count, period_out, no_signal, lat);
    check("edge_count", int'(edge_count), e.edges);
    check("period_out", int'(period_out), e.period);
    check("no_signal", int'(no_signal), int'(e.nosig));
    if (e.lat >= 0) check("valid_latency", lat, e.lat);
  endtask

  task automatic do_ack();
    meas_ack = 1'b1;
    @(negedge clk);
    meas_ack = 1'b0;
    check("valid_after_ack", int'(meas_valid), 0);
  endtask

  task automatic run_vector(input vec_t v);
    int lat;
    bit ok;
    half_period = 0;
    repeat (4) @(negedge clk);
    half_period = v.half;
    gate_sel    = v.gsel;
    start       = 1'b1;
    sb.push_back('{v.edges, v.period, v.nosig, v.nosig ? (64 << v.gsel) : -1});
    wait_valid(1'b1, lat, ok);
    if (ok) check_result(lat);
    do_ack();
  endtask

  initial begin
    int lat;
    bit ok;
    int seen;

    vecs[0] = '{2'd0, 11, 3, 22, 1'b0};
    vecs[1] = '{2'd1, 11, 6, 22, 1'b0};
    vecs[2] = '{2'd0, 4, 8, 8, 1'b0};
    vecs[3] = '{2'd0, 0, 0, 0, 1'b1};
    vecs[4] = '{2'd3, 1, 255, 2, 1'b0};
    vecs[5] = '{2'd0, 40, 1, 0, 1'b0};
    vecs[6] = '{2'd3, 150, 2, 255, 1'b0};
    vecs[7] = '{2'd2, 5, 26, 10, 1'b0};

    #2 rst_n = 1'b0;
    #5;
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(meas_valid), 0);
    check("rst_no_signal", int'(no_signal), 0);
    check("rst_edge_count", int'(edge_count), 0);
    check("rst_period_out", int'(period_out), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ena   = 1'b1;

    foreach (vecs[k]) run_vector(vecs[k]);

    // Reset in the middle of MEASURE discards everything.
    half_period = 11;
    gate_sel    = 2'd0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_valid", int'(meas_valid), 0);
    check("midrst_edge_count", int'(edge_count), 0);
    check("midrst_period_out", int'(period_out), 0);
    check("midrst_no_signal", int'(no_signal), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (meas_valid) seen++;
    end
    check("no_valid_after_reset", seen, 0);

    // Result held while meas_ack stays low.
    gate_sel = 2'd0;
    start    = 1'b1;
    sb.push_back('{3, 22, 1'b0, -1});
    wait_valid(1'b0, lat, ok);
    if (ok) begin
      repeat (20) @(negedge clk);
      check("held_valid", int'(meas_valid), 1);
      check_result(lat);
    end

    // Back-to-back: start and ack together in HOLD.
    gate_sel = 2'd1;
    start    = 1'b1;
    meas_ack = 1'b1;
    sb.push_back('{6, 22, 1'b0, -1});
    wait_valid(1'b0, lat, ok);
    if (ok) check_result(lat);
    do_ack();

    // Dropping ena mid-measurement returns to IDLE but keeps the last result.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    check("ena_busy", int'(busy), 0);
    check("ena_valid", int'(meas_valid), 0);
    check("ena_edge_count_kept", int'(edge_count), 6);
    check("ena_period_kept", int'(period_out), 22);
    ena  = 1'b1;
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (meas_valid || busy) seen++;
    end
    check("idle_after_ena", seen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
